// File: rtl/itype_pkg.sv
// Shared definitions for the I-type execution unit: opcodes, FSM states and
// instruction field positions.
package itype_pkg;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        WB     = 2'd3
    } itypeState_e;

    function automatic logic isLegalOp(input logic [5:0] op);
        logic legal;
        case (op)
            OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_ANDI, OP_ORI, OP_LUI: legal = 1'b1;
            default:                 legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/itype_regfile.sv
// 32x32 register file: host and writeback write ports (writeback wins),
// registered operand read and combinational debug read.
module itype_regfile #(
    parameter int ZERO_REG0 = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hostWe,
    input  logic [4:0]  hostWaddr,
    input  logic [31:0] hostWdata,
    input  logic        wbWe,
    input  logic [4:0]  wbWaddr,
    input  logic [31:0] wbWdata,
    input  logic        rdEn,
    input  logic [4:0]  rdAddr,
    output logic [31:0] rdData,
    input  logic [4:0]  dbgAddr,
    output logic [31:0] dbgData
);

    logic [31:0] regs_r [32];
    logic [31:0] rdData_r;

    // Register array update; r0 is pinned to zero when ZERO_REG0 is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'd0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if ((ZERO_REG0 != 0) && (i == 0)) begin
                    regs_r[i] <= 32'd0;
                end else if (wbWe && (wbWaddr == 5'(i))) begin
                    regs_r[i] <= wbWdata;
                end else if (hostWe && (hostWaddr == 5'(i))) begin
                    regs_r[i] <= hostWdata;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Operand read samples the pre-write contents, so same-cycle writes are not forwarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdData_r <= 32'd0;
        end else if (rdEn) begin
            rdData_r <= regs_r[rdAddr];
        end else begin
            rdData_r <= rdData_r;
        end
    end

    assign rdData  = rdData_r;
    assign dbgData = regs_r[dbgAddr];

endmodule

// File: rtl/itype_exec_unit.sv
// Handshaked multi-cycle MIPS I-type execution unit:
// IDLE -> DECODE -> EXEC -> WB, with a host preload port and debug read.
module itype_exec_unit
    import itype_pkg::*;
#(
    parameter int ZERO_REG0 = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic        host_we,
    input  logic [4:0]  host_waddr,
    input  logic [31:0] host_wdata,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        ovf,
    output logic        illegal
);

    itypeState_e state_r, nextState_s;
    logic [31:0] inst_r;
    logic [31:0] opA_s;
    logic [31:0] immSext_s, immZext_s, sum_s, aluValue_s;
    logic        addiOvf_s;
    logic [5:0]  opcode_s;
    logic [4:0]  rs_s, rt_s;
    logic [15:0] imm_s;
    logic        instReady_r, resultValid_r, ovf_r, illegal_r;
    logic [31:0] result_r;
    logic        wbWe_s;

    assign opcode_s  = inst_r[OPC_HI:OPC_LO];
    assign rs_s      = inst_r[RS_HI:RS_LO];
    assign rt_s      = inst_r[RT_HI:RT_LO];
    assign imm_s     = inst_r[IMM_HI:IMM_LO];
    assign immSext_s = {{16{imm_s[15]}}, imm_s};
    assign immZext_s = {16'h0000, imm_s};
    assign sum_s     = opA_s + immSext_s;

    // An overflowing ADDI still reports its wrapped sum but never reaches rt.
    assign wbWe_s = (state_r == WB) && !ovf_r;

    itype_regfile #(
        .ZERO_REG0 (ZERO_REG0)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .hostWe    (host_we),
        .hostWaddr (host_waddr),
        .hostWdata (host_wdata),
        .wbWe      (wbWe_s),
        .wbWaddr   (rt_s),
        .wbWdata   (result_r),
        .rdEn      (state_r == DECODE),
        .rdAddr    (rs_s),
        .rdData    (opA_s),
        .dbgAddr   (dbg_raddr),
        .dbgData   (dbg_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE: begin
                if (inst_valid) begin
                    nextState_s = DECODE;
                end else begin
                    nextState_s = IDLE;
                end
            end
            DECODE: begin
                if (isLegalOp(opcode_s)) begin
                    nextState_s = EXEC;
                end else begin
                    nextState_s = IDLE;
                end
            end
            EXEC:    nextState_s = WB;
            WB:      nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    // Instruction latch on handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= 32'd0;
        end else if ((state_r == IDLE) && inst_valid) begin
            inst_r <= inst;
        end else begin
            inst_r <= inst_r;
        end
    end

    // Immediate ALU.
    always_comb begin
        aluValue_s = result_r;
        addiOvf_s  = 1'b0;
        case (opcode_s)
            OP_ADDI: begin
                aluValue_s = sum_s;
                addiOvf_s  = (opA_s[31] == immSext_s[31]) && (sum_s[31] != opA_s[31]);
            end
            OP_ADDIU: aluValue_s = sum_s;
            OP_SLTI:  aluValue_s = {31'd0, ($signed(opA_s) < $signed(immSext_s))};
            OP_ANDI:  aluValue_s = opA_s & immZext_s;
            OP_ORI:   aluValue_s = opA_s | immZext_s;
            OP_LUI:   aluValue_s = {imm_s, 16'h0000};
            default:  aluValue_s = result_r;
        endcase
    end

    // Registered outputs; pulses are set one cycle ahead so they coincide with WB or the return to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instReady_r   <= 1'b1;
            resultValid_r <= 1'b0;
            ovf_r         <= 1'b0;
            illegal_r     <= 1'b0;
            result_r      <= 32'd0;
        end else begin
            instReady_r   <= (nextState_s == IDLE);
            resultValid_r <= (state_r == EXEC);
            ovf_r         <= (state_r == EXEC) && addiOvf_s;
            illegal_r     <= (state_r == DECODE) && !isLegalOp(opcode_s);
            if (state_r == EXEC) begin
                result_r <= aluValue_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign inst_ready   = instReady_r;
    assign result       = result_r;
    assign result_valid = resultValid_r;
    assign ovf          = ovf_r;
    assign illegal      = illegal_r;

endmodule

// File: tb/tb_itype_exec_unit.sv
// Directed-vector bench for itype_exec_unit with hand-computed expectations.
module tb_itype_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic        host_we;
    logic [4:0]  host_waddr;
    logic [31:0] host_wdata;
    logic [4:0]  dbg_raddr;
    logic [31:0] dbg_rdata;
    logic [31:0] result;
    logic        result_valid;
    logic        ovf;
    logic        illegal;

    int errCount;
    int checkCount;

    itype_exec_unit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .inst         (inst),
        .host_we      (host_we),
        .host_waddr   (host_waddr),
        .host_wdata   (host_wdata),
        .dbg_raddr    (dbg_raddr),
        .dbg_rdata    (dbg_rdata),
        .result       (result),
        .result_valid (result_valid),
        .ovf          (ovf),
        .illegal      (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic hostWrite(input logic [4:0] a, input logic [31:0] d);
        host_we    = 1'b1;
        host_waddr = a;
        host_wdata = d;
        @(posedge clk);
        #1;
        host_we = 1'b0;
    endtask

    // Returns one time unit into cycle T+1.
    task automatic issue(input logic [31:0] ins);
        int n;
        n = 0;
        while (!inst_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkEq("ready_before_issue", 32'(inst_ready), 32'd1);
        inst_valid = 1'b1;
        inst       = ins;
        @(posedge clk);
        #1;
        inst_valid = 1'b0;
        inst       = 32'hFFFF_FFFF;
    endtask

    // hostCyc selects the cycle (1 = DECODE, 3 = WB) in which a host write collides.
    task automatic runInst(input string tag, input logic [31:0] ins, input logic [31:0] expRes,
                           input logic expOvf, input logic [4:0] rtA, input logic [31:0] expRt,
                           input int hostCyc, input logic [4:0] hA, input logic [31:0] hD);
        issue(ins);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            case (c)
                1: checkEq({tag, "_ready_T1"}, 32'(inst_ready), 32'd0);
                2: checkEq({tag, "_rv_T2"}, 32'(result_valid), 32'd0);
                3: begin
                    checkEq({tag, "_rv_T3"}, 32'(result_valid), 32'd1);
                    checkEq({tag, "_result_T3"}, result, expRes);
                    checkEq({tag, "_ovf_T3"}, 32'(ovf), 32'(expOvf));
                    dbg_raddr = rtA;
                end
                4: begin
                    checkEq({tag, "_rt_T4"}, dbg_rdata, expRt);
                    checkEq({tag, "_rv_T4"}, 32'(result_valid), 32'd0);
                    checkEq({tag, "_ready_T4"}, 32'(inst_ready), 32'd1);
                end
                default: ;
            endcase
            host_we    = (c == hostCyc);
            host_waddr = hA;
            host_wdata = hD;
        end
        host_we = 1'b0;
    endtask

    initial begin
        errCount   = 0;
        checkCount = 0;
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst       = 32'd0;
        host_we    = 1'b0;
        host_waddr = 5'd0;
        host_wdata = 32'd0;
        dbg_raddr  = 5'd1;

        repeat (2) @(negedge clk);
        checkEq("rst_ready", 32'(inst_ready), 32'd1);
        checkEq("rst_result", result, 32'd0);
        checkEq("rst_pulses", {29'd0, result_valid, ovf, illegal}, 32'd0);
        checkEq("rst_r1", dbg_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        hostWrite(5'd0, 32'd2);
        runInst("addi", 32'h2001_0001, 32'd3, 1'b0, 5'd1, 32'd3, 0, 5'd0, 32'd0);

        hostWrite(5'd2, 32'hFFFF_FFFF);
        runInst("andi", 32'h3043_8000, 32'h0000_8000, 1'b0, 5'd3, 32'h0000_8000, 0, 5'd0, 32'd0);
        hostWrite(5'd0, 32'd0);
        runInst("ori", 32'h3404_FFFF, 32'h0000_FFFF, 1'b0, 5'd4, 32'h0000_FFFF, 0, 5'd0, 32'd0);

        hostWrite(5'd4, 32'h7FFF_FFFF);
        runInst("addi_ovf", 32'h2085_0001, 32'h8000_0000, 1'b1, 5'd5, 32'd0, 0, 5'd0, 32'd0);
        runInst("addiu_wrap", 32'h2485_0001, 32'h8000_0000, 1'b0, 5'd5, 32'h8000_0000, 0, 5'd0, 32'd0);

        // Illegal opcode aimed at r1, which must keep its value.
        dbg_raddr = 5'd1;
        issue(32'h0001_0005);
        @(negedge clk);
        checkEq("ill_T1", 32'(illegal), 32'd0);
        checkEq("ill_ready_T1", 32'(inst_ready), 32'd0);
        @(negedge clk);
        checkEq("ill_T2", 32'(illegal), 32'd1);
        checkEq("ill_ready_T2", 32'(inst_ready), 32'd1);
        checkEq("ill_rv_T2", 32'(result_valid), 32'd0);
        checkEq("ill_result", result, 32'h8000_0000);
        @(negedge clk);
        checkEq("ill_T3", 32'(illegal), 32'd0);
        checkEq("ill_r1", dbg_rdata, 32'd3);

        runInst("lui", 32'h3C06_1234, 32'h1234_0000, 1'b0, 5'd6, 32'h1234_0000, 0, 5'd0, 32'd0);
        runInst("addi_dep", 32'h20C7_FFFF, 32'h1233_FFFF, 1'b0, 5'd7, 32'h1233_FFFF, 0, 5'd0, 32'd0);

        hostWrite(5'd6, 32'hFFFF_FFF0);
        runInst("slti_neg", 32'h28C8_0000, 32'd1, 1'b0, 5'd8, 32'd1, 0, 5'd0, 32'd0);
        runInst("slti_pos", 32'h2829_0000, 32'd0, 1'b0, 5'd9, 32'd0, 0, 5'd0, 32'd0);

        runInst("wb_wins", 32'h240A_0005, 32'd5, 1'b0, 5'd10, 32'd5, 3, 5'd10, 32'h0000_DEAD);
        runInst("no_fwd", 32'h242B_0000, 32'd3, 1'b0, 5'd11, 32'd3, 1, 5'd1, 32'd100);
        dbg_raddr = 5'd1;
        #1;
        checkEq("host_r1", dbg_rdata, 32'd100);
        runInst("rt_eq_rs", 32'h2421_0001, 32'd101, 1'b0, 5'd1, 32'd101, 0, 5'd0, 32'd0);

        // Reset asserted while the unit sits in EXEC.
        issue(32'h240C_0007);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkEq("mid_rst_ready", 32'(inst_ready), 32'd1);
        checkEq("mid_rst_result", result, 32'd0);
        checkEq("mid_rst_pulses", {29'd0, result_valid, ovf, illegal}, 32'd0);
        checkEq("mid_rst_r1", dbg_rdata, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dbg_raddr = 5'd12;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkEq("post_rst_rv", 32'(result_valid), 32'd0);
        end
        checkEq("post_rst_r12", dbg_rdata, 32'd0);
        runInst("post_rst_addi", 32'h2001_0001, 32'd1, 1'b0, 5'd1, 32'd1, 0, 5'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
